// File: rtl/ps2_key_event_ctrl.sv
// PS/2 Set-2 scan-code sequencer: folds E0/F0 prefixes into key events
// and buffers them in a first-word-fall-through FIFO for the register bank.
module ps2_key_event_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_err,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_sticky,
  input  logic             irq_en,
  output logic             evt_valid,
  output logic [9:0]       evt_data,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf,
  output logic             seq_err,
  output logic             rx_err_flag,
  output logic             kbd_ovf,
  output logic             irq
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       CODE_EXT  = 8'hE0;
  localparam logic [7:0]       CODE_BRK  = 8'hF0;
  localparam logic [7:0]       CODE_ERR0 = 8'h00;
  localparam logic [7:0]       CODE_ERR1 = 8'hFF;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             emit;
  logic [9:0]       emit_data;
  logic             is_prefix;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic             do_pop;
  logic             do_wr;
  logic             drop;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [9:0]       head_nxt;

  assign is_prefix = (rx_byte == CODE_EXT) || (rx_byte == CODE_BRK);

  // Prefix tracker; a decoded event is registered and lands in the FIFO one edge later.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      emit        <= 1'b0;
      emit_data   <= '0;
      seq_err     <= 1'b0;
      kbd_ovf     <= 1'b0;
      rx_err_flag <= 1'b0;
    end else begin
      emit <= 1'b0;
      if (clr_sticky) begin
        seq_err     <= 1'b0;
        kbd_ovf     <= 1'b0;
        rx_err_flag <= 1'b0;
      end
      if (rx_err) rx_err_flag <= 1'b1;

      if (flush || rx_err) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else if (rx_valid) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (rx_byte == CODE_EXT) begin
              state <= EXT;
            end else if (rx_byte == CODE_BRK) begin
              state <= BRK;
            end else if ((rx_byte == CODE_ERR0) || (rx_byte == CODE_ERR1)) begin
              kbd_ovf <= 1'b1;
            end else begin
              emit      <= 1'b1;
              emit_data <= {2'b00, rx_byte};
            end
          end
          EXT: begin
            if (rx_byte == CODE_BRK) begin
              state <= EXT_BRK;
            end else if (rx_byte != CODE_EXT) begin
              emit      <= 1'b1;
              emit_data <= {2'b10, rx_byte};
              state     <= IDLE;
            end
          end
          BRK, EXT_BRK: begin
            state <= IDLE;
            if (is_prefix) begin
              seq_err <= 1'b1;
            end else begin
              emit      <= 1'b1;
              emit_data <= {state == EXT_BRK, 1'b1, rx_byte};
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A byte on the expiry cycle takes the branch above instead.
        if (tmo_cnt == TMO_LAST) begin
          seq_err <= 1'b1;
          state   <= IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Next FIFO state; the head register is preloaded so evt_data is already valid after each edge.
  always_comb begin
    do_pop   = pop && (evt_count != '0) && !flush;
    do_wr    = emit && !flush && ((evt_count != CNT_FULL) || do_pop);
    drop     = emit && !flush && (evt_count == CNT_FULL) && !do_pop;
    rd_nxt   = rd_ptr + PTR_W'(do_pop);
    cnt_nxt  = evt_count + CNT_W'(do_wr) - CNT_W'(do_pop);
    head_nxt = '0;
    if (flush) cnt_nxt = '0;
    if (cnt_nxt != '0) begin
      head_nxt = (do_wr && (wr_ptr == rd_nxt)) ? emit_data : mem[rd_nxt];
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_wr) mem[wr_ptr] <= emit_data;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      evt_count <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
      ovf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_nxt;
        if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      end
      evt_count <= cnt_nxt;
      evt_valid <= (cnt_nxt != '0);
      evt_data  <= head_nxt;
      if (clr_sticky) ovf <= 1'b0;
      if (drop) ovf <= 1'b1;
      irq <= evt_valid && irq_en;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_ps2_key_event_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 20;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_err;
  logic          pop;
  logic          flush;
  logic          clr_sticky;
  logic          irq_en;
  logic          evt_valid;
  logic [9:0]    evt_data;
  logic [CW-1:0] evt_count;
  logic          ovf;
  logic          seq_err;
  logic          rx_err_flag;
  logic          kbd_ovf;
  logic          irq;

  ps2_key_event_ctrl #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_err     (rx_err),
    .pop        (pop),
    .flush      (flush),
    .clr_sticky (clr_sticky),
    .irq_en     (irq_en),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_count  (evt_count),
    .ovf        (ovf),
    .seq_err    (seq_err),
    .rx_err_flag(rx_err_flag),
    .kbd_ovf    (kbd_ovf),
    .irq        (irq)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: event queue, pending prefix bits, idle age since last byte.
  logic [9:0] q[$];
  bit         in_seq, m_ext, m_brk;
  int         age;
  bit         pend_v;
  logic [9:0] pend_d;
  bit         m_ovf, m_seq, m_rxe, m_kbd, m_irq;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         s_ovf = 0, s_seq = 0, s_rxe = 0, s_kbd = 0, nv = 0;
    logic [9:0] nd = '0;
    bit         pfx;
    if (ARESET) begin
      q.delete();
      in_seq = 0; m_ext = 0; m_brk = 0; age = 0;
      pend_v = 0; pend_d = '0;
      m_ovf = 0; m_seq = 0; m_rxe = 0; m_kbd = 0; m_irq = 0;
      return;
    end
    m_irq = (q.size() > 0) && irq_en;
    // FIFO stage: the event decoded on the previous edge arrives now.
    if (flush) q.delete();
    else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (pend_v) begin
        if (q.size() < DEPTH) q.push_back(pend_d);
        else s_ovf = 1;
      end
    end
    // Byte stage.
    pfx = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
    if (rx_err) s_rxe = 1;
    if (flush || rx_err) in_seq = 0;
    else if (rx_valid) begin
      age = 0;
      if (!in_seq) begin
        if (rx_byte == 8'hE0) begin in_seq = 1; m_ext = 1; m_brk = 0; end
        else if (rx_byte == 8'hF0) begin in_seq = 1; m_ext = 0; m_brk = 1; end
        else if (rx_byte == 8'h00 || rx_byte == 8'hFF) s_kbd = 1;
        else begin nv = 1; nd = {2'b00, rx_byte}; end
      end else if (m_brk) begin
        if (pfx) s_seq = 1;
        else begin nv = 1; nd = {m_ext, 1'b1, rx_byte}; end
        in_seq = 0;
      end else begin
        if (rx_byte == 8'hF0) m_brk = 1;
        else if (rx_byte != 8'hE0) begin nv = 1; nd = {2'b10, rx_byte}; in_seq = 0; end
      end
    end else if (in_seq) begin
      age++;
      if (age == TMO) begin s_seq = 1; in_seq = 0; end
    end
    m_ovf = s_ovf || (m_ovf && !clr_sticky);
    m_seq = s_seq || (m_seq && !clr_sticky);
    m_rxe = s_rxe || (m_rxe && !clr_sticky);
    m_kbd = s_kbd || (m_kbd && !clr_sticky);
    pend_v = nv;
    pend_d = nd;
  endtask

  task automatic compare_all();
    check("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
    check("evt_data", 32'(evt_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    check("evt_count", 32'(evt_count), 32'(q.size()));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("seq_err", 32'(seq_err), 32'(m_seq));
    check("rx_err_flag", 32'(rx_err_flag), 32'(m_rxe));
    check("kbd_ovf", 32'(kbd_ovf), 32'(m_kbd));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic cycle();
    @(posedge ACLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(bit v, logic [7:0] b, bit e, bit p, bit f, bit c);
    rx_valid = v; rx_byte = b; rx_err = e; pop = p; flush = f; clr_sticky = c;
    cycle();
    rx_valid = 0; rx_err = 0; pop = 0; flush = 0; clr_sticky = 0;
  endtask

  task automatic send(logic [7:0] b);
    drive(1, b, 0, 0, 0, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic do_pop();
    drive(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic do_clr();
    drive(0, 8'h00, 0, 0, 0, 1);
  endtask

  initial begin
    ARESET = 1; rx_valid = 0; rx_byte = 0; rx_err = 0;
    pop = 0; flush = 0; clr_sticky = 0; irq_en = 0;
    repeat (3) cycle();
    check("rst_count", 32'(evt_count), 32'h0);
    check("rst_data", 32'(evt_data), 32'h0);
    ARESET = 0;

    // Basic make/break/extended decode.
    send(8'h1C); send(8'hE0); send(8'h75); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    check("seq4_count", 32'(evt_count), 32'd4);
    check("seq4_head0", 32'(evt_data), 32'h01C);
    check("seq4_flags", 32'({ovf, seq_err, rx_err_flag, kbd_ovf}), 32'h0);
    do_pop(); check("seq4_head1", 32'(evt_data), 32'h275);
    do_pop(); check("seq4_head2", 32'(evt_data), 32'h11C);
    do_pop(); check("seq4_head3", 32'(evt_data), 32'h375);
    do_pop(); do_pop();
    check("empty_pop_data", 32'(evt_data), 32'h0);
    check("empty_pop_count", 32'(evt_count), 32'h0);

    // Overflow, then pop+emit while full.
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
    idle(2);
    check("full_count", 32'(evt_count), 32'd16);
    check("full_ovf", 32'(ovf), 32'd1);
    check("full_head", 32'(evt_data), 32'h010);
    send(8'h55);
    do_pop();
    check("full_popwr_count", 32'(evt_count), 32'd16);
    for (int i = 0; i < 15; i++) do_pop();
    check("full_tail", 32'(evt_data), 32'h055);
    do_pop(); do_clr();

    // Illegal prefix order, then timeout.
    send(8'hF0); send(8'hE0); idle(1);
    check("badseq_err", 32'(seq_err), 32'd1);
    check("badseq_count", 32'(evt_count), 32'd0);
    do_clr();
    send(8'hE0); idle(TMO); send(8'h1C); idle(1);
    check("tmo_err", 32'(seq_err), 32'd1);
    check("tmo_event", 32'(evt_data), 32'h01C);
    do_pop(); do_clr();

    // Byte on the expiry cycle wins.
    send(8'hE0); idle(TMO - 1); send(8'h6B); idle(1);
    check("expiry_event", 32'(evt_data), 32'h26B);
    check("expiry_err", 32'(seq_err), 32'd0);
    do_pop();

    // rx_err discards the prefix; 00 in IDLE is a keyboard overrun.
    send(8'hE0); drive(0, 8'h00, 1, 0, 0, 0); send(8'h75); idle(1);
    check("rxerr_flag", 32'(rx_err_flag), 32'd1);
    check("rxerr_event", 32'(evt_data), 32'h075);
    do_pop();
    send(8'h00); idle(1);
    check("kbd_flag", 32'(kbd_ovf), 32'd1);
    check("kbd_count", 32'(evt_count), 32'd0);
    do_clr();

    // flush with entries, an arriving event and a new byte.
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    drive(1, 8'h45, 0, 0, 1, 0);
    check("flush_count", 32'(evt_count), 32'd0);
    idle(1);
    check("flush_count2", 32'(evt_count), 32'd0);

    // clr_sticky coinciding with a fresh overflow.
    for (int i = 0; i < 17; i++) send(8'h20 + 8'(i));
    send(8'h66);
    do_clr();
    check("clr_vs_ovf", 32'(ovf), 32'd1);
    drive(0, 8'h00, 0, 0, 1, 1);

    // irq timing.
    irq_en = 1;
    send(8'h12);
    idle(1);
    check("irq_lag_valid", 32'(evt_valid), 32'd1);
    check("irq_lag", 32'(irq), 32'd0);
    idle(1);
    check("irq_on", 32'(irq), 32'd1);
    do_pop();
    check("irq_hold", 32'(irq), 32'd1);
    idle(1);
    check("irq_off", 32'(irq), 32'd0);

    // Reset mid-sequence.
    send(8'h33); send(8'hE0);
    ARESET = 1; drive(1, 8'h75, 0, 1, 0, 0); ARESET = 0;
    check("midrst_count", 32'(evt_count), 32'd0);
    idle(2);

    // Random traffic with alternating drain rates.
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] b;
      int         pop_pct;
      pop_pct = ((n / 500) % 2 == 1) ? 45 : 8;
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF;
        default: b = 8'($urandom_range(1, 254));
      endcase
      if ($urandom_range(0, 99) == 0) idle(TMO - 1 + int'($urandom_range(0, 2)));
      irq_en = ($urandom_range(0, 9) != 0);
      ARESET = ($urandom_range(0, 799) == 0);
      drive($urandom_range(0, 99) < 50, b,
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 99) < pop_pct,
            $urandom_range(0, 299) == 0,
            $urandom_range(0, 99) == 0);
      ARESET = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

- Sequences raw PS/2 scan-code bytes from the keyboard byte receiver into decoded key events and buffers them in a FIFO for the AXI4-Lite register bank of the PS/2 keyboard debug IP.
- Tracks the Set-2 prefixes E0 (extended) and F0 (break) with a small state machine and enforces an inter-byte timeout on partial sequences.
- Exposes a first-word-fall-through event head, fill count, sticky error flags and an interrupt level to the register file.

## Interface
Parameters
- FIFO_DEPTH, 16: event FIFO entries; power of two, ≥ 2.
- TIMEOUT_CYCLES, 100000: maximum cycles allowed between bytes of a prefixed sequence (1 ms at 100 MHz); ≥ 2.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of the fill count.

Ports
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous reset, active high.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- rx_byte  in  8  received scan-code byte.
- rx_err  in  1  one-cycle strobe for a parity or framing error on the current frame.
- pop  in  1  one-cycle strobe from the event-data register read; removes the head entry.
- flush  in  1  one-cycle strobe; empties the FIFO and returns the FSM to IDLE.
- clr_sticky  in  1  one-cycle strobe; clears ovf, seq_err, rx_err_flag and kbd_ovf.
- irq_en  in  1  interrupt enable from the control register.
- evt_valid  out  1  FIFO not empty.
- evt_data  out  10  head entry: [9] extended, [8] break, [7:0] code. Reads 0 when the FIFO is empty.
- evt_count  out  CNT_W  number of entries, 0..FIFO_DEPTH.
- ovf  out  1  sticky; an event was dropped because the FIFO was full.
- seq_err  out  1  sticky; illegal prefix order, or a prefix sequence timed out.
- rx_err_flag  out  1  sticky; rx_err was seen.
- kbd_ovf  out  1  sticky; the keyboard sent 00 or FF (its own buffer overrun or error).
- irq  out  1  evt_valid AND irq_en, registered.

## Operation
FSM states: IDLE, EXT, BRK, EXT_BRK. Each transition below is taken on a cycle with rx_valid=1 and rx_err=0.
- IDLE
  - E0 → EXT.
  - F0 → BRK.
  - 00 or FF → set kbd_ovf, no event, stay in IDLE.
  - Any other byte b → emit {0,0,b}.
- EXT
  - F0 → EXT_BRK.
  - E0 → stay in EXT (a repeated prefix is tolerated).
  - Any other byte b → emit {1,0,b}, go to IDLE.
- BRK
  - E0 or F0 → set seq_err, go to IDLE, no event.
  - Any other byte b → emit {0,1,b}, go to IDLE.
- EXT_BRK
  - E0 or F0 → set seq_err, go to IDLE, no event.
  - Any other byte b → emit {1,1,b}, go to IDLE.
- In EXT, BRK and EXT_BRK, 00 and FF are treated as ordinary codes and emitted.
- rx_err=1 (with or without rx_valid): set rx_err_flag, go to IDLE, discard any pending prefix, and ignore the byte.
- Timeout counter
  - Resets to 0 on every accepted byte and whenever the FSM is in IDLE.
  - Increments each cycle in EXT, BRK or EXT_BRK.
  - On reaching TIMEOUT_CYCLES-1: set seq_err and go to IDLE.
  - If a byte arrives on the expiry cycle, the byte wins; the timeout is not taken.
- FIFO write
  - An emit writes the tail entry.
  - If the FIFO is full and there is no pop in the same cycle, the event is dropped, ovf is set, and count is unchanged.
- FIFO read (pop)
  - pop while the FIFO is empty is ignored.
  - pop together with an emit in the same cycle: both take effect, including when the FIFO is full; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. evt_count is maintained as a separate counter, never as a pointer difference.
- flush overrides pop and emit in the same cycle: FIFO becomes empty, FSM goes to IDLE, timeout counter clears. Sticky flags are untouched.
- Sticky flags: if clr_sticky and a set event occur in the same cycle, set wins.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pointers and count 0, timeout counter 0.
- Emit latency: rx_valid at rising edge N is written at edge N+1; evt_valid, evt_data and evt_count reflect it after N+1.
- Pop: the next head entry (or 0) is visible the cycle after the pop edge.
- Sticky flags update at the edge after their cause.
- irq follows evt_valid AND irq_en with one cycle of registration.
- Throughput: one byte per cycle is accepted, with no backpressure. rx_valid has no ready signal.
- ARESET asserted mid-sequence or mid-pop returns everything to reset values at the next edge.

## Test plan
- Reset, then bytes 1C; E0 75; F0 1C; E0 F0 75 → four entries in order: 0x01C, 0x275, 0x11C, 0x375; evt_count=4; no flags set.
- 17 emits into a FIFO_DEPTH=16 FIFO with no pop → evt_count=16, ovf=1, head still the first code. Then one pop together with an emit while full → count stays 16 and the new code lands at the tail.
- F0 then E0 → seq_err=1, no event. Then E0 followed by TIMEOUT_CYCLES idle cycles, then 1C → seq_err=1 and event 0x01C (non-extended).
- rx_err strobe between E0 and 75 → rx_err_flag=1, event 0x075 (non-extended). 00 in IDLE → kbd_ovf=1, no event.
- Pop while empty → no change, evt_data=0. flush with 3 entries and a simultaneous emit → evt_count=0 at the next cycle, flags unchanged. clr_sticky coinciding with a new overflow → ovf stays 1.
- irq_en=1 with first event written at edge N → irq=1 from edge N+1 onward; pop the last entry → irq falls one cycle after evt_valid falls.
